// File: rtl/oam_dma_controller.sv
// oam_dma_controller: halts the CPU and copies one 256-byte page to PPU $2004 as
// alternating read/write CPU ticks, with reads aligned to even ticks.
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_WE,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_rdy,
    output logic        bus_sel,
    output logic [15:0] bus_addr,
    output logic        bus_WE,
    output logic [7:0]  bus_data_out,
    output logic        dma_done
);
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t     state, state_nxt;
    logic       parity;
    logic [7:0] idx;
    logic [7:0] page;
    logic       trig;
    logic       last;

    assign trig = cpu_WE && cpu_addr == DMA_REG_ADDR;
    assign last = idx == LAST_IDX;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else if (cpu_ce) state <= state_nxt;
    end

    // parity holds the current tick's parity, so an odd HALT tick means the next tick is even
    always_comb begin
        state_nxt = state == IDLE  ? (trig ? HALT : IDLE) :
                    state == HALT  ? (parity ? READ : ALIGN) :
                    state == ALIGN ? READ :
                    state == READ  ? WRITE :
                    last           ? IDLE : READ;
    end

    always_comb begin
        cpu_rdy  = state == IDLE;
        bus_sel  = !cpu_rdy;
        bus_WE   = state == WRITE;
        bus_addr = state == READ  ? {page, idx} :
                   state == WRITE ? OAM_DATA_ADDR : 16'h0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity       <= 1'b0;
            idx          <= 8'h00;
            page         <= 8'h00;
            bus_data_out <= 8'h00;
            dma_done     <= 1'b0;
        end else begin
            dma_done <= cpu_ce && state == WRITE && last;
            if (cpu_ce) begin
                parity <= ~parity;
                if (state == IDLE && trig) begin
                    page <= cpu_data_in;
                    idx  <= 8'h00;
                end
                if (state == READ) bus_data_out <= mem_data_in;
                if (state == WRITE && !last) idx <= idx + 8'h01;
            end
        end
    end
endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: table-driven DMA transfers against a behavioural RAM,
// plus hand sequences for mid-transfer reset and non-ce register writes.
module tb_oam_dma_controller;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_ce = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        cpu_WE = 1'b0;
    logic [7:0]  mem_data_in = 8'h00;
    logic        cpu_rdy, bus_sel, bus_WE, dma_done;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;

    oam_dma_controller dut (
        .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .cpu_WE(cpu_WE), .mem_data_in(mem_data_in),
        .cpu_rdy(cpu_rdy), .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_WE(bus_WE),
        .bus_data_out(bus_data_out), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:65535];
    always @(posedge clk) mem_data_in <= ram[bus_addr];

    int ntests = 0, nfail = 0;
    int tcount = 0, nstall = 0, nwr = 0, ndone = 0, bad_wr = 0, bad_rd = 0, viol = 0;
    logic [15:0] prev_addr = 16'h0, last_rd = 16'h0;
    logic        prev_we = 1'b0, prev_sel = 1'b0;
    logic [7:0]  cur_page = 8'h00;
    bit          noise = 1'b0;

    // Observe each tick on the negedge before its active edge; tcount equals the DUT's parity count
    always @(negedge clk) begin
        if (!reset_n) tcount = 0;
        else begin
            if (bus_sel == cpu_rdy) viol++;
            if (bus_WE && !bus_sel) viol++;
            if (dma_done) begin
                ndone++;
                if (!cpu_rdy) viol++;
            end
            if (cpu_ce) begin
                if (!cpu_rdy) nstall++;
                if (bus_WE) begin
                    if (bus_addr != 16'h2004 || bus_data_out != ram[{cur_page, 8'(nwr)}]) bad_wr++;
                    if (prev_addr != {cur_page, 8'(nwr)} || prev_we || !prev_sel || tcount % 2 != 1) bad_rd++;
                    last_rd = prev_addr;
                    nwr++;
                end
                prev_addr = bus_addr;
                prev_we   = bus_WE;
                prev_sel  = bus_sel;
                tcount++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // gap-1 idle clocks (optionally carrying $4014 writes without ce), then one tick
    task automatic tick(input int gap, input logic we, input logic [7:0] d);
        for (int k = 1; k < gap; k++) begin
            cpu_ce = 1'b0; cpu_WE = noise; cpu_addr = 16'h4014; cpu_data_in = 8'h07;
            @(posedge clk); #1;
        end
        cpu_ce = 1'b1; cpu_WE = we; cpu_addr = we ? 16'h4014 : 16'h0000; cpu_data_in = d;
        @(posedge clk); #1;
        cpu_ce = 1'b0; cpu_WE = 1'b0; cpu_addr = 16'h0000;
    endtask

    task automatic clear_counts();
        nstall = 0; nwr = 0; ndone = 0; bad_wr = 0; bad_rd = 0; viol = 0;
    endtask

    typedef struct {
        logic [7:0]  page;
        int          trig_par;
        int          gap;
        bit          noise;
        bit          inject;
        int          exp_stall;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'(a) ^ 8'h5A ^ (8'(a >> 8) - 8'h02);
        // trig_par is the DUT parity at the trigger tick: 0 = odd tick counting from 1, no ALIGN
        vecs[0] = '{8'h02, 0, 2, 1'b0, 1'b0, 513, 16'h02FF};
        vecs[1] = '{8'h02, 1, 2, 1'b0, 1'b0, 514, 16'h02FF};
        vecs[2] = '{8'hFF, 0, 2, 1'b0, 1'b0, 513, 16'hFFFF};
        vecs[3] = '{8'h03, 1, 2, 1'b0, 1'b1, 514, 16'h03FF};
        vecs[4] = '{8'h00, 0, 3, 1'b1, 1'b0, 513, 16'h00FF};
        vecs[5] = '{8'h20, 1, 3, 1'b1, 1'b0, 514, 16'h20FF};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("rst cpu_rdy", int'(cpu_rdy), 1);
        check("rst bus_sel", int'(bus_sel), 0);
        check("rst bus_addr", int'(bus_addr), 0);
        check("rst bus_WE", int'(bus_WE), 0);
        check("rst bus_data_out", int'(bus_data_out), 0);
        check("rst dma_done", int'(dma_done), 0);

        noise = 1'b1;
        clear_counts();
        for (int k = 0; k < 8; k++) tick(3, 1'b0, 8'h00);
        check("nonce stall", nstall, 0);
        check("nonce bus_sel", int'(bus_sel), 0);

        for (int v = 0; v < 6; v++) begin
            int n;
            noise = vecs[v].noise;
            while (tcount % 2 != vecs[v].trig_par) tick(vecs[v].gap, 1'b0, 8'h00);
            cur_page = vecs[v].page;
            clear_counts();
            tick(vecs[v].gap, 1'b1, vecs[v].page);
            n = 0;
            while (ndone == 0 && n < 600) begin
                tick(vecs[v].gap, vecs[v].inject && n == 100, 8'h07);
                n++;
            end
            tick(vecs[v].gap, 1'b0, 8'h00);
            tick(vecs[v].gap, 1'b0, 8'h00);
            check($sformatf("v%0d stall", v), nstall, vecs[v].exp_stall);
            check($sformatf("v%0d writes", v), nwr, 256);
            check($sformatf("v%0d bad_wr", v), bad_wr, 0);
            check($sformatf("v%0d bad_rd", v), bad_rd, 0);
            check($sformatf("v%0d done", v), ndone, 1);
            check($sformatf("v%0d last_rd", v), int'(last_rd), int'(vecs[v].exp_last));
            check($sformatf("v%0d viol", v), viol, 0);
            check($sformatf("v%0d cpu_rdy", v), int'(cpu_rdy), 1);
        end

        noise = 1'b0;
        cur_page = 8'h02;
        clear_counts();
        tick(2, 1'b1, 8'h02);
        for (int n = 0; n < 200 && !(bus_WE && nwr == 37); n++) tick(2, 1'b0, 8'h00);
        check("mid WRITE reached", int'(bus_WE && nwr == 37), 1);
        reset_n = 1'b0;
        #1;
        check("arst bus_WE", int'(bus_WE), 0);
        check("arst bus_sel", int'(bus_sel), 0);
        check("arst cpu_rdy", int'(cpu_rdy), 1);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        clear_counts();
        for (int k = 0; k < 20; k++) tick(2, 1'b0, 8'h00);
        check("post rst writes", nwr, 0);
        check("post rst stall", nstall, 0);
        check("post rst done", ndone, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
